// File: rtl/imm_encoder.sv
// Searches the 16 even rotations (lowest first) for an 8-bit immediate that reproduces value.
// Define IMM_ENCODER_FASTPATH_EN to finish values below 256 straight from IDLE.
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [3:0]  imm_rotate,
    output logic [7:0]  imm_8
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] val_q;
    logic [3:0]  cnt_q;
    logic        valid_q;
    logic [3:0]  rot_q;
    logic [7:0]  imm_q;

    logic [4:0]  shamt_d;
    logic [31:0] cand_d;
    logic        hit_d;

    // A right shift by 32 yields zero, so r=0 needs no special case.
    always_comb begin
        shamt_d = {cnt_q, 1'b0};
        cand_d  = (val_q << shamt_d) | (val_q >> (6'd32 - {1'b0, shamt_d}));
        hit_d   = (cand_d[31:8] == 24'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= 32'd0;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            rot_q   <= 4'd0;
            imm_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        val_q <= value;
                        cnt_q <= 4'd0;
`ifdef IMM_ENCODER_FASTPATH_EN
                        if (value[31:8] == 24'd0) begin
                            valid_q <= 1'b1;
                            rot_q   <= 4'd0;
                            imm_q   <= value[7:0];
                            state_q <= DONE;
                        end else begin
                            state_q <= SEARCH;
                        end
`else
                        state_q <= SEARCH;
`endif
                    end
                end
                SEARCH: begin
                    if (hit_d) begin
                        valid_q <= 1'b1;
                        rot_q   <= cnt_q;
                        imm_q   <= cand_d[7:0];
                        state_q <= DONE;
                    end else if (cnt_q == 4'd15) begin
                        valid_q <= 1'b0;
                        rot_q   <= 4'd0;
                        imm_q   <= 8'd0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q == SEARCH);
    assign done       = (state_q == DONE);
    assign valid      = valid_q;
    assign imm_rotate = rot_q;
    assign imm_8      = imm_q;

endmodule
